// File: rtl/pulse_emitter.sv
// Turns single-cycle trigger requests into fixed-width high pulses separated by a guaranteed low gap.
// Define PULSE_EMITTER_QUEUE_EN to queue requests that arrive while a pulse is in flight.
module pulse_emitter #(
  parameter int HIGH_LEN = 4,
  parameter int GAP_LEN  = 4,
  parameter int QDEPTH_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trig_in,
  output logic                pulse_out,
  output logic                busy,
  output logic [QDEPTH_W-1:0] pending,
  output logic                drop
);

  localparam int MAX_LEN = (HIGH_LEN > GAP_LEN) ? HIGH_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  phase_cnt;
  logic              gap_exit;
  logic              inflight_req;

  // The GAP-exit edge belongs to the start logic, never to request accounting.
  assign gap_exit     = (state == GAP) && (phase_cnt == GAP_LAST);
  assign inflight_req = trig_in && (state != IDLE) && !gap_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: state and outputs update together with non-blocking assignments,
      // so every branch below reads the values from before this edge.
      case (state)
        IDLE: begin
          if (trig_in) begin
            state     <= HIGH;
            phase_cnt <= '0;
            pulse_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_cnt == HIGH_LAST) begin
            state     <= GAP;
            phase_cnt <= '0;
            pulse_out <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_exit) begin
            phase_cnt <= '0;
            if ((pending != '0) || trig_in) begin
              state     <= HIGH;
              pulse_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          phase_cnt <= '0;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_EMITTER_QUEUE_EN
  localparam logic [QDEPTH_W-1:0] PEND_MAX = '1;

  logic pend_full;
  logic start_from_q;

  assign pend_full    = (pending == PEND_MAX);
  assign start_from_q = gap_exit && (pending != '0);

  // A coincident trigger at a queued start replaces the consumed request: net zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= inflight_req && pend_full;
      if (inflight_req && !pend_full) begin
        pending <= pending + QDEPTH_W'(1);
      end else if (start_from_q && !trig_in) begin
        pending <= pending - QDEPTH_W'(1);
      end
    end
  end
`else
  assign pending = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else begin
      drop <= inflight_req;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_emitter.sv
// Directed bench for pulse_emitter (HIGH_LEN=4, GAP_LEN=4, QDEPTH_W=2); expectations follow
// PULSE_EMITTER_QUEUE_EN the same way the design does.
module tb_pulse_emitter;

  localparam int QW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig_in = 1'b0;
  logic          pulse_out;
  logic          busy;
  logic [QW-1:0] pending;
  logic          drop;

  int checks = 0;
  int failures = 0;

  pulse_emitter #(
    .HIGH_LEN (4),
    .GAP_LEN  (4),
    .QDEPTH_W (QW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_in   (trig_in),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Character i of a vector string as a digit; positions past the end read as 0.
  function automatic int digit(input string s, input int i);
    if (i < s.len()) return int'(s[i]) - 48;
    return 0;
  endfunction

  // One character per cycle: drive trig, clock once, compare {pulse,busy,pending,drop}.
  task automatic run_seq(input string tag, input int n, input string trig, input string pls,
                         input string bsy, input string pnd, input string drp);
    logic [4:0] exp_v;
    for (int i = 0; i < n; i++) begin
      trig_in = (digit(trig, i) == 1);
      @(posedge clk);
      #1;
      exp_v = {digit(pls, i) == 1, digit(bsy, i) == 1, QW'(digit(pnd, i)), digit(drp, i) == 1};
      check($sformatf("%s@c%0d", tag, i + 1), 32'({pulse_out, busy, pending, drop}), 32'(exp_v));
    end
    trig_in = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_state", 32'({pulse_out, busy, pending, drop}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq("single", 10, "1", "1111", "11111111", "", "");

    run_seq("gap_exit_p0", 18, "100000001", "1111000011110000", "1111111111111111", "", "");

`ifdef PULSE_EMITTER_QUEUE_EN
    run_seq("three_trig", 26, "111", "111100001111000011110000",
            "111111111111111111111111", "01222222111111110", "");
    run_seq("saturate", 34, "11111", "11110000111100001111000011110000",
            "11111111111111111111111111111111",
            "01233333222222221111111100", "00001");
    run_seq("gap_exit_p2", 34, "111000001", "11110000111100001111000011110000",
            "11111111111111111111111111111111",
            "0122222222222222111111110", "");
    run_seq("gap_trig", 18, "100001", "1111000011110000", "1111111111111111", "00000111", "");
    run_seq("pre_reset", 3, "111", "111", "111", "012", "");
`else
    run_seq("three_trig", 12, "111", "1111", "11111111", "", "011");
    run_seq("saturate", 12, "11111", "1111", "11111111", "", "01111");
    run_seq("gap_exit_p2", 18, "111000001", "1111000011110000", "1111111111111111", "", "011");
    run_seq("gap_trig", 10, "100001", "1111", "11111111", "", "000001");
    run_seq("pre_reset", 3, "111", "111", "111", "", "011");
`endif

    // Asynchronous reset in the middle of a pulse with requests queued.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({pulse_out, busy, pending, drop}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("post_reset", 12, "", "", "", "", "");

    run_seq("restart", 10, "1", "1111", "11111111", "", "");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
